// File: rtl/snake_body_renderer.sv
// rtl/snake_body_renderer.sv - snake body buffer, 2-stage pixel renderer and head collision flag
//
// Purpose:
//   Holds the snake body as a shift buffer of up to MAX_SEG segment top-left
//   corners. Each iStep shifts the body one slot towards the tail and loads the
//   new head; iGrow qualifies the step and lengthens the snake by one.
//   Renders body, head, frame and level item per pixel with a fixed 2-clock
//   latency, and optionally flags head collisions.
//
// Ports:
//   iVGA_CLK            pixel clock
//   iRST                synchronous reset, active-high
//   iVGA_X / iVGA_Y     current pixel coordinate from the VGA timing controller
//   iHead_X / iHead_Y   new head top-left corner, sampled on iStep
//   iStep               1-cycle strobe, advances the body
//   iGrow               qualifies iStep, adds one segment (saturates at MAX_SEG)
//   iLevel              0 = apple item, 1 = heart item, 2/3 = no item
//   iItem_X / iItem_Y   item top-left corner
//   oRed/oGreen/oBlue   colour channels to the DAC
//   oLen                current segment count
//   oCollide            sticky collision flag (cleared only by iRST)
//
// Configuration:
//   SNAKE_COLLIDE_EN    when defined, builds the self/frame collision detector;
//                       otherwise oCollide is tied low.

module snake_body_renderer #(
  parameter int MAX_SEG  = 16,
  parameter int INIT_LEN = 4,
  parameter int SEG_SIZE = 20,
  parameter int BORDER   = 20,
  parameter int H_ACT    = 640,
  parameter int V_ACT    = 480,
  parameter int COORD_W  = 10,
  parameter int COLOR_W  = 10
) (
  input  logic                         iVGA_CLK,
  input  logic                         iRST,
  input  logic [COORD_W-1:0]           iVGA_X,
  input  logic [COORD_W-1:0]           iVGA_Y,
  input  logic [COORD_W-1:0]           iHead_X,
  input  logic [COORD_W-1:0]           iHead_Y,
  input  logic                         iStep,
  input  logic                         iGrow,
  input  logic [1:0]                   iLevel,
  input  logic [COORD_W-1:0]           iItem_X,
  input  logic [COORD_W-1:0]           iItem_Y,
  output logic [COLOR_W-1:0]           oRed,
  output logic [COLOR_W-1:0]           oGreen,
  output logic [COLOR_W-1:0]           oBlue,
  output logic [$clog2(MAX_SEG+1)-1:0] oLen,
  output logic                         oCollide
);

  localparam int LEN_W = $clog2(MAX_SEG + 1);
  // One extra bit so corner + SEG_SIZE never wraps at the right/bottom edge.
  localparam int SW = COORD_W + 1;

  localparam logic [COLOR_W-1:0] FS       = '1;
  localparam logic [SW-1:0]      SEG_W    = SW'(SEG_SIZE);
  localparam logic [SW-1:0]      BORDER_W = SW'(BORDER);
  localparam logic [SW-1:0]      RIGHT_W  = SW'(H_ACT - BORDER);
  localparam logic [SW-1:0]      BOTTOM_W = SW'(V_ACT - BORDER);
  localparam logic [SW-1:0]      H_ACT_W  = SW'(H_ACT);
  localparam logic [SW-1:0]      V_ACT_W  = SW'(V_ACT);

  logic [COORD_W-1:0] segX [MAX_SEG];
  logic [COORD_W-1:0] segY [MAX_SEG];
  logic [LEN_W-1:0]   len;

  // Body buffer and length
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      for (int k = 0; k < MAX_SEG; k++) begin
        if (k < INIT_LEN) begin
          segX[k] <= COORD_W'(BORDER + (INIT_LEN - 1 - k) * SEG_SIZE);
          segY[k] <= COORD_W'(V_ACT / 2);
        end else begin
          segX[k] <= '0;
          segY[k] <= '0;
        end
      end
      len <= LEN_W'(INIT_LEN);
    end else if (iStep) begin
      for (int k = MAX_SEG - 1; k > 0; k--) begin
        segX[k] <= segX[k-1];
        segY[k] <= segY[k-1];
      end
      segX[0] <= iHead_X;
      segY[0] <= iHead_Y;
      // The old tail is already shifted into slot len, so growing just exposes it.
      if (iGrow && (len < LEN_W'(MAX_SEG))) begin
        len <= len + 1'b1;
      end
    end
  end

  assign oLen = len;

  // Per-pixel hit tests (combinational, registered in S1)
  logic [SW-1:0]      px, py, ix, iy;
  logic [MAX_SEG-1:0] hitVec;
  logic               frameOn, itemOn, activeOn;

  assign px = {1'b0, iVGA_X};
  assign py = {1'b0, iVGA_Y};
  assign ix = {1'b0, iItem_X};
  assign iy = {1'b0, iItem_Y};

  // Segment squares are exclusive on all four edges, leaving a 1-pixel gap
  // between neighbouring segments. Segments past the current length are masked.
  for (genvar g = 0; g < MAX_SEG; g++) begin : gHit
    logic [SW-1:0] sx, sy;
    assign sx = {1'b0, segX[g]};
    assign sy = {1'b0, segY[g]};
    assign hitVec[g] = (LEN_W'(g) < len) &&
                       (px > sx) && (px < sx + SEG_W) &&
                       (py > sy) && (py < sy + SEG_W);
  end

  assign frameOn  = (px < BORDER_W) || (px >= RIGHT_W) ||
                    (py < BORDER_W) || (py >= BOTTOM_W);
  assign activeOn = (px < H_ACT_W) && (py < V_ACT_W);
  // Item square is inclusive on both edges; levels 2/3 carry no item.
  assign itemOn   = !iLevel[1] &&
                    (px >= ix) && (px <= ix + SEG_W) &&
                    (py >= iy) && (py <= iy + SEG_W);

  // S1 flags and S2 colour resolve
  logic [MAX_SEG-1:0] s1Hit;
  logic               s1Frame, s1Item, s1Heart, s1Active;

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      s1Hit    <= '0;
      s1Frame  <= 1'b0;
      s1Item   <= 1'b0;
      s1Heart  <= 1'b0;
      s1Active <= 1'b0;
      oRed     <= '0;
      oGreen   <= '0;
      oBlue    <= '0;
    end else begin
      s1Hit    <= hitVec;
      s1Frame  <= frameOn;
      s1Item   <= itemOn;
      s1Heart  <= iLevel[0];
      s1Active <= activeOn;

      if (!s1Active) begin
        oRed <= '0; oGreen <= '0; oBlue <= '0;
      end else if (|s1Hit[MAX_SEG-1:1]) begin
        oRed <= '0; oGreen <= FS; oBlue <= '0;
      end else if (s1Hit[0]) begin
        oRed <= FS; oGreen <= FS; oBlue <= '0;
      end else if (s1Frame) begin
        oRed <= FS; oGreen <= FS; oBlue <= FS;
      end else if (s1Item) begin
        oRed <= FS; oGreen <= '0; oBlue <= s1Heart ? FS : '0;
      end else begin
        oRed <= '0; oGreen <= '0; oBlue <= '0;
      end
    end
  end

`ifdef SNAKE_COLLIDE_EN
  // New head against old seg[0..len-2]; the old tail slot is vacated by the step.
  logic [MAX_SEG-1:0] selfHit;
  logic [SW-1:0]      hx, hy;
  logic               headFrame;
  logic               collideR;

  assign hx = {1'b0, iHead_X};
  assign hy = {1'b0, iHead_Y};

  for (genvar g = 0; g < MAX_SEG; g++) begin : gSelf
    assign selfHit[g] = (LEN_W'(g + 1) < len) &&
                        (segX[g] == iHead_X) && (segY[g] == iHead_Y);
  end

  // Head square [h, h+SEG_SIZE) must sit fully inside the playfield interior.
  assign headFrame = (hx < BORDER_W) || (hx + SEG_W > RIGHT_W) ||
                     (hy < BORDER_W) || (hy + SEG_W > BOTTOM_W);

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      collideR <= 1'b0;
    end else if (iStep && ((|selfHit) || headFrame)) begin
      collideR <= 1'b1;
    end
  end

  assign oCollide = collideR;
`else
  assign oCollide = 1'b0;
`endif

endmodule

// File: tb/tb_snake_body_renderer.sv
// tb/tb_snake_body_renderer.sv - self-checking bench for snake_body_renderer

module tb_snake_body_renderer;

  localparam int MAX_SEG  = 16;
  localparam int INIT_LEN = 4;
  localparam int SEG_SIZE = 20;
  localparam int BORDER   = 20;
  localparam int H_ACT    = 640;
  localparam int V_ACT    = 480;
  localparam int COORD_W  = 10;
  localparam int COLOR_W  = 10;
  localparam int LEN_W    = $clog2(MAX_SEG + 1);
  localparam int RGB_W    = 3 * COLOR_W;

  localparam logic [COLOR_W-1:0] FS = '1;
  localparam logic [COLOR_W-1:0] ZR = '0;

`ifdef SNAKE_COLLIDE_EN
  localparam logic COL_EXP = 1'b1;
`else
  localparam logic COL_EXP = 1'b0;
`endif

  logic                iVGA_CLK = 1'b0;
  logic                iRST     = 1'b1;
  logic [COORD_W-1:0]  iVGA_X   = '0;
  logic [COORD_W-1:0]  iVGA_Y   = '0;
  logic [COORD_W-1:0]  iHead_X  = '0;
  logic [COORD_W-1:0]  iHead_Y  = '0;
  logic                iStep    = 1'b0;
  logic                iGrow    = 1'b0;
  logic [1:0]          iLevel   = 2'd3;
  logic [COORD_W-1:0]  iItem_X  = '0;
  logic [COORD_W-1:0]  iItem_Y  = '0;
  logic [COLOR_W-1:0]  oRed, oGreen, oBlue;
  logic [LEN_W-1:0]    oLen;
  logic                oCollide;

  snake_body_renderer dut (
    .iVGA_CLK (iVGA_CLK),
    .iRST     (iRST),
    .iVGA_X   (iVGA_X),
    .iVGA_Y   (iVGA_Y),
    .iHead_X  (iHead_X),
    .iHead_Y  (iHead_Y),
    .iStep    (iStep),
    .iGrow    (iGrow),
    .iLevel   (iLevel),
    .iItem_X  (iItem_X),
    .iItem_Y  (iItem_Y),
    .oRed     (oRed),
    .oGreen   (oGreen),
    .oBlue    (oBlue),
    .oLen     (oLen),
    .oCollide (oCollide)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  int passCnt  = 0;
  int failCnt  = 0;
  int totalCnt = 0;

  // Reference model: body as a list, head at the front.
  int mX[$];
  int mY[$];
  int mLen;
  bit mCol;
  logic [RGB_W-1:0] expQ[$];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCnt++;
    assert (observed === expected) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mX.delete();
    mY.delete();
    for (int k = 0; k < MAX_SEG; k++) begin
      mX.push_back(k < INIT_LEN ? BORDER + (INIT_LEN - 1 - k) * SEG_SIZE : 0);
      mY.push_back(k < INIT_LEN ? V_ACT / 2 : 0);
    end
    mLen = INIT_LEN;
    mCol = 1'b0;
  endtask

  function automatic bit inSeg(int x, int y, int sx, int sy);
    return (x > sx) && (x < sx + SEG_SIZE) && (y > sy) && (y < sy + SEG_SIZE);
  endfunction

  function automatic logic [RGB_W-1:0] modelColour(int x, int y);
    bit body = 1'b0;
    int lvl = int'(iLevel);
    int ix  = int'(iItem_X);
    int iy  = int'(iItem_Y);
    if (x >= H_ACT || y >= V_ACT) return {ZR, ZR, ZR};
    for (int i = 1; i < mLen; i++) body |= inSeg(x, y, mX[i], mY[i]);
    if (body) return {ZR, FS, ZR};
    if (inSeg(x, y, mX[0], mY[0])) return {FS, FS, ZR};
    if (x < BORDER || x >= H_ACT - BORDER || y < BORDER || y >= V_ACT - BORDER)
      return {FS, FS, FS};
    if (lvl < 2 && x >= ix && x <= ix + SEG_SIZE && y >= iy && y <= iy + SEG_SIZE)
      return (lvl == 0) ? {FS, ZR, ZR} : {FS, ZR, FS};
    return {ZR, ZR, ZR};
  endfunction

  task automatic modelStep(input int hx, input int hy, input bit grow);
`ifdef SNAKE_COLLIDE_EN
    for (int i = 0; i <= mLen - 2; i++)
      if (mX[i] == hx && mY[i] == hy) mCol = 1'b1;
    if (hx < BORDER || hx + SEG_SIZE > H_ACT - BORDER ||
        hy < BORDER || hy + SEG_SIZE > V_ACT - BORDER) mCol = 1'b1;
`endif
    mX.push_front(hx);
    mY.push_front(hy);
    void'(mX.pop_back());
    void'(mY.pop_back());
    if (grow && mLen < MAX_SEG) mLen++;
  endtask

  // One pixel clock: drive, advance, then check the pixel driven one call earlier.
  task automatic cyc(input int x, input int y, input bit step, input int hx, input int hy,
                     input bit grow, input bit rst);
    logic [RGB_W-1:0] e;
    iVGA_X  = COORD_W'(x);
    iVGA_Y  = COORD_W'(y);
    iStep   = step;
    iHead_X = COORD_W'(hx);
    iHead_Y = COORD_W'(hy);
    iGrow   = grow;
    iRST    = rst;
    if (rst) begin
      expQ.delete();
      expQ.push_back('0);
      expQ.push_back('0);
    end else begin
      expQ.push_back(modelColour(x, y));
    end
    @(posedge iVGA_CLK);
    #1;
    if (rst) modelReset();
    else if (step) modelStep(hx, hy, grow);
    iStep = 1'b0;
    iGrow = 1'b0;
    iRST  = 1'b0;
    if (expQ.size() >= 2) begin
      e = expQ.pop_front();
      check("rgb", 32'({oRed, oGreen, oBlue}), 32'(e));
    end
    check("len", 32'(oLen), 32'(mLen));
    check("collide", 32'(oCollide), 32'(mCol));
  endtask

  task automatic pix(input int x, input int y);
    cyc(x, y, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rgbNow();
    return 32'({oRed, oGreen, oBlue});
  endfunction

  int hx, hy, k, px, py;

  initial begin
    modelReset();
    iLevel  = 2'd3;
    cyc(0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
    cyc(0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
    check("rst_rgb", rgbNow(), 32'(0));
    check("rst_len", 32'(oLen), 32'(INIT_LEN));
    check("rst_col", 32'(oCollide), 32'(0));

    // 1: head interior is yellow, 2 clocks after the pixel is presented
    pix(BORDER + 70, V_ACT / 2 + 10);
    pix(0, 0);
    check("t1_head", rgbNow(), 32'({FS, FS, ZR}));
    check("t1_len", 32'(oLen), 32'(4));

    // 2: one plain step drops the old tail at (20,240)
    cyc(0, 0, 1'b1, 120, 240, 1'b0, 1'b0);
    pix(130, 250);
    pix(30, 250);
    check("t2_newhead", rgbNow(), 32'({FS, FS, ZR}));
    pix(0, 0);
    check("t2_oldtail", rgbNow(), 32'(0));
    check("t2_len", 32'(oLen), 32'(4));

    // 3: grow saturates at MAX_SEG
    for (int i = 1; i <= 13; i++) cyc(0, 0, 1'b1, 120 + 20 * i, 240, 1'b1, 1'b0);
    check("t3_len16", 32'(oLen), 32'(16));
    cyc(0, 0, 1'b1, 400, 240, 1'b1, 1'b0);
    check("t3_hold16", 32'(oLen), 32'(16));
    pix(395, 250);
    pix(0, 0);
    check("t3_body", rgbNow(), 32'({ZR, FS, ZR}));

    // 4: item colour per level
    iItem_X = 10'd300;
    iItem_Y = 10'd200;
    iLevel = 2'd0; pix(310, 210);
    iLevel = 2'd1; pix(310, 210);
    check("t4_apple", rgbNow(), 32'({FS, ZR, ZR}));
    iLevel = 2'd2; pix(310, 210);
    check("t4_heart", rgbNow(), 32'({FS, ZR, FS}));
    pix(0, 0);
    check("t4_none", rgbNow(), 32'(0));
    pix(5, 100);
    pix(700, 100);
    check("t4_frame", rgbNow(), 32'({FS, FS, FS}));
    pix(0, 0);
    check("t4_inactive", rgbNow(), 32'(0));

    // 5: collisions (self, then frame)
    cyc(0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
    cyc(0, 0, 1'b1, 40, 240, 1'b0, 1'b0);
    check("t5_self", 32'(oCollide), 32'(COL_EXP));
    cyc(0, 0, 1'b1, 100, 240, 1'b0, 1'b0);
    check("t5_sticky", 32'(oCollide), 32'(COL_EXP));
    cyc(0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
    check("t5_clear", 32'(oCollide), 32'(0));
    cyc(0, 0, 1'b1, 0, 240, 1'b0, 1'b0);
    check("t5_frame", 32'(oCollide), 32'(COL_EXP));
    cyc(0, 0, 1'b0, 0, 0, 1'b0, 1'b1);

    // Randomised streaming against the model
    hx = 100;
    hy = 240;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        iLevel  = 2'($urandom_range(0, 3));
        iItem_X = COORD_W'($urandom_range(0, 700));
        iItem_Y = COORD_W'($urandom_range(0, 500));
      end
      if ($urandom_range(0, 1) == 0) begin
        k  = int'($urandom_range(0, MAX_SEG - 1));
        px = (mX[k] + int'($urandom_range(0, 24)) + 1022) % 1024;
        py = (mY[k] + int'($urandom_range(0, 24)) + 1022) % 1024;
      end else if ($urandom_range(0, 1) == 0) begin
        px = (int'(iItem_X) + int'($urandom_range(0, 24)) + 1022) % 1024;
        py = (int'(iItem_Y) + int'($urandom_range(0, 24)) + 1022) % 1024;
      end else begin
        px = int'($urandom_range(0, 1023));
        py = int'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 4))
          0: hx = (hx + 20) % 1024;
          1: hx = (hx + 1004) % 1024;
          2: hy = (hy + 20) % 1024;
          3: hy = (hy + 1004) % 1024;
          default: begin
            hx = int'($urandom_range(0, 1023));
            hy = int'($urandom_range(0, 1023));
          end
        endcase
        cyc(px, py, 1'b1, hx, hy, 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        pix(px, py);
      end
    end

    // 6: reset pulse mid-stream flushes the pipeline to black
    pix(BORDER + 5, 100);
    pix(5, 5);
    cyc(5, 5, 1'b0, 0, 0, 1'b0, 1'b1);
    check("t6_flush0", rgbNow(), 32'(0));
    check("t6_len", 32'(oLen), 32'(INIT_LEN));
    check("t6_col", 32'(oCollide), 32'(0));
    pix(5, 5);
    check("t6_flush1", rgbNow(), 32'(0));
    pix(0, 0);
    check("t6_resume", rgbNow(), 32'({FS, FS, FS}));

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
